// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data-memory responder.
// FSM encoding, default geometry/latency and the word-index width helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1001_0000;
  localparam int          DEF_DEPTH_WORDS = 256;
  localparam int          DEF_WAIT_CYCLES = 2;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word store with registered read.
// Contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH_WORDS,
  parameter int IW    = idx_w(DEF_DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [IW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory slave with range/error checks.
// Define DMEM_ALIGN_CHECK_EN to flag non-word-aligned addresses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dErr
);

  localparam int IW = idx_w(DEPTH_WORDS);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          rd_q;
  logic          wr_q;
  logic          err_q;
  logic          rdy_q;
  logic          derr_q;
  logic [31:0]   hold_q;

  logic [31:0]   off_w;
  logic [31:0]   word_w;
  logic          oor_w;
  logic          mis_w;
  logic          bad_w;
  logic          go_w;
  logic          acc_w;
  logic          arr_we;
  logic          arr_re;
  logic [31:0]   arr_rdata;

  assign off_w  = dAddress - BASE_ADDR;
  assign word_w = off_w >> 2;
  assign oor_w  = (dAddress < BASE_ADDR) ||
                  (word_w >= 32'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_w = |dAddress[1:0];
`else
  assign mis_w = 1'b0;
`endif

  assign bad_w = (MemRead & MemWrite) | oor_w | mis_w;
  assign go_w  = MemRead | MemWrite;

  // The access fires on the edge that leaves WAIT.
  assign acc_w  = (state_q == WAIT) && (cnt_q == 4'd0);
  assign arr_we = acc_w & wr_q & ~err_q;
  assign arr_re = acc_w & rd_q & ~err_q;

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .IW    (IW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      derr_q  <= 1'b0;
      hold_q  <= 32'd0;
    end else begin
      rdy_q  <= 1'b0;
      derr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go_w) begin
            idx_q   <= word_w[IW-1:0];
            wdata_q <= dWriteData;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            err_q   <= bad_w;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            rdy_q   <= 1'b1;
            derr_q  <= err_q;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rd_q) begin
            hold_q <= err_q ? 32'd0 : arr_rdata;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fresh read data is shown in RESP, then held until the next read.
  always_comb begin
    dReadData = hold_q;
    if (state_q == RESP && rd_q) begin
      dReadData = err_q ? 32'd0 : arr_rdata;
    end
  end

  assign dReady = rdy_q;
  assign dErr   = derr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random + directed checks against a word-array model.
// Second instance runs with zero wait states.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int DEPTH = 256;
  localparam int WC    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        rd, wr, rdy, err;
  logic [31:0] ad, wd, rdq;
  logic        rd0, wr0, rdy0, err0;
  logic [31:0] ad0, wd0, rdq0;

  dmem_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)
  ) u_dut (
    .clk(clk), .rst(rst_n),
    .MemRead(rd), .MemWrite(wr),
    .dAddress(ad), .dWriteData(wd),
    .dReadData(rdq), .dReady(rdy), .dErr(err)
  );

  dmem_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .rst(rst_n),
    .MemRead(rd0), .MemWrite(wr0),
    .dAddress(ad0), .dWriteData(wd0),
    .dReadData(rdq0), .dReady(rdy0), .dErr(err0)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_rd = 32'd0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_err(input logic r, input logic w,
                                 input logic [31:0] a);
    logic [31:0] off;
    logic e;
    off = a - BASE;
    e = (r && w) || (a < BASE) || ((off / 4) >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (a % 4 != 0) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic txn(input bit sel, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit hold, output int lat,
                     output logic e, output logic [31:0] q);
    @(negedge clk);
    if (sel) begin
      rd0 = r; wr0 = w; ad0 = a; wd0 = d;
    end else begin
      rd = r; wr = w; ad = a; wd = d;
    end
    @(posedge clk);
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (sel ? rdy0 : rdy) break;
    end
    e = sel ? err0 : err;
    q = sel ? rdq0 : rdq;
    if (!hold) begin
      @(negedge clk);
      rd = 0; wr = 0; rd0 = 0; wr0 = 0;
    end
  endtask

  task automatic do_chk(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit hold);
    int lat;
    logic e, ee;
    logic [31:0] q, eq;
    logic [31:0] idx;
    txn(1'b0, r, w, a, d, hold, lat, e, q);
    ee  = m_err(r, w, a);
    idx = (a - BASE) / 4;
    eq  = last_rd;
    if (r) eq = ee ? 32'd0 : mdl[idx];
    if (w && !ee) mdl[idx] = d;
    last_rd = eq;
    check({tag, ".lat"}, 32'(lat), 32'(WC + 2));
    check({tag, ".err"}, {31'd0, e}, {31'd0, ee});
    check({tag, ".rdata"}, q, eq);
  endtask

  initial begin
    int lat, gap, k;
    logic e;
    logic [31:0] q, a;
    rd = 0; wr = 0; ad = 0; wd = 0;
    rd0 = 0; wr0 = 0; ad0 = 0; wd0 = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst.rdy", {31'd0, rdy}, 32'd0);
    check("rst.err", {31'd0, err}, 32'd0);
    check("rst.rdata", rdq, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      do_chk("init", 1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 1'b0);

    do_chk("st_beef", 1'b0, 1'b1, 32'h1001_0008, 32'hDEADBEEF, 1'b0);
    do_chk("ld_beef", 1'b1, 1'b0, 32'h1001_0008, 32'd0, 1'b0);
    check("ld_beef.val", last_rd, 32'hDEADBEEF);
    do_chk("ld_end", 1'b1, 1'b0, 32'h1001_0400, 32'd0, 1'b0);
    @(posedge clk); #1;
    check("idle.rdy", {31'd0, rdy}, 32'd0);
    check("idle.err", {31'd0, err}, 32'd0);
    do_chk("st_low", 1'b0, 1'b1, 32'h1000_FFFC, 32'hCAFE0001, 1'b0);
    do_chk("ld_w0a", 1'b1, 1'b0, BASE, 32'd0, 1'b0);
    do_chk("both", 1'b1, 1'b1, BASE, 32'h0BAD0BAD, 1'b0);
    do_chk("ld_w0b", 1'b1, 1'b0, BASE, 32'd0, 1'b0);
    do_chk("ld_mis", 1'b1, 1'b0, 32'h1001_0002, 32'd0, 1'b0);

    do_chk("held1", 1'b1, 1'b0, BASE + 32'd20, 32'd0, 1'b1);
    gap = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      gap++;
      if (rdy) break;
    end
    check("held2.gap", 32'(gap), 32'(WC + 3));
    check("held2.rdata", rdq, mdl[5]);
    @(negedge clk); rd = 0;

    do_chk("pre0", 1'b0, 1'b1, 32'h1001_0010, 32'd0, 1'b0);
    do_chk("pre_rd", 1'b1, 1'b0, 32'h1001_0008, 32'd0, 1'b0);
    @(negedge clk);
    wr = 1; ad = 32'h1001_0010; wd = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.rdy", {31'd0, rdy}, 32'd0);
    check("abort.err", {31'd0, err}, 32'd0);
    check("abort.rdata", rdq, 32'd0);
    last_rd = 32'd0;
    @(negedge clk);
    wr = 0;
    rst_n = 1'b1;
    do_chk("abort_ld", 1'b1, 1'b0, 32'h1001_0010, 32'd0, 1'b0);
    check("abort_ld.val", last_rd, 32'd0);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 4);
      if (k == 0) a = BASE - 32'(4 * $urandom_range(1, 64));
      else if (k == 1) a = BASE + 32'd1024 + 32'(4 * $urandom_range(0, 64));
      else a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      k = $urandom_range(0, 9);
      do_chk("rnd", (k < 4) || (k == 8) || (k == 9),
             (k >= 4) && (k <= 8), a, $urandom, 1'b0);
    end

    txn(1'b1, 1'b0, 1'b1, BASE + 32'd4, 32'hA5A5_5A5A, 1'b0, lat, e, q);
    check("w0.lat", 32'(lat), 32'd2);
    check("w0.err", {31'd0, e}, 32'd0);
    txn(1'b1, 1'b1, 1'b0, BASE + 32'd4, 32'd0, 1'b0, lat, e, q);
    check("r0.lat", 32'(lat), 32'd2);
    check("r0.rdata", q, 32'hA5A5_5A5A);
    @(posedge clk); #1;
    check("r0.pulse", {31'd0, rdy0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
